// File: rtl/am25ls2521_eqcmp_pkg.sv
// am25ls2521_eqcmp_pkg
// Shared constants for the identity comparator slice.
// The equal indication is active-low throughout, so the constants are
// named by meaning rather than by level.
package am25ls2521_eqcmp_pkg;

  localparam logic EQ_ACTIVE   = 1'b0;  // operands equal and compare enabled
  localparam logic EQ_INACTIVE = 1'b1;  // not equal, or compare disabled

endpackage

// File: rtl/am25ls2521_eqcmp_if.sv
// am25ls2521_eqcmp_if
// Groups the comparator operand and result signals.
//   a, b    : operands (WIDTH bits)
//   ein_    : active-low cascade enable
//   eout_   : combinational active-low equal
//   eout_q  : eout_ registered one cycle
//   diff_q  : registered per-bit mismatch, zero while disabled
// master : the side that supplies operands and observes results
// slave  : the comparator itself
interface am25ls2521_eqcmp_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ein_;
  logic             eout_;
  logic             eout_q;
  logic [WIDTH-1:0] diff_q;

  modport master (
    output a, b, ein_,
    input  eout_, eout_q, diff_q
  );

  modport slave (
    input  a, b, ein_,
    output eout_, eout_q, diff_q
  );

endinterface

// File: rtl/am25ls2521_eqcmp_core.sv
// am25ls2521_core
// Purely combinational identity compare.
//   a_i, b_i : operands
//   ein_i    : active-low enable, 1 forces "not equal"
//   eout_o   : active-low equal
//   diff_o   : raw per-bit mismatch (a XOR b), not gated by enable
module am25ls2521_core
  import am25ls2521_eqcmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ein_i,
  output logic             eout_o,
  output logic [WIDTH-1:0] diff_o
);

  assign diff_o = a_i ^ b_i;

  // Reduction OR rather than ==, so one known differing bit yields a known
  // "not equal" even when the remaining bits are X/Z; ein_=1 likewise
  // dominates any unknown operand.
  assign eout_o = ein_i | (|diff_o);

endmodule

// File: rtl/am25ls2521_eqcmp.sv
// am25ls2521_eqcmp
// N-bit identity comparator with active-low cascade enable and equal out.
// The combinational eout_ is kept for cascading (stage k eout_ feeds
// stage k+1 ein_); registered copies are provided for status/debug.
//   clk : system clock, registers update on rising edge
//   rst : synchronous active-high reset (does not touch eout_)
//   cmp : comparator signals, see am25ls2521_eqcmp_if
module am25ls2521_eqcmp
  import am25ls2521_eqcmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  am25ls2521_eqcmp_if.slave cmp
);

  logic             eout_c;
  logic [WIDTH-1:0] diff_c;

  logic             eout_reg_d;
  logic             eout_reg_q;
  logic [WIDTH-1:0] diff_reg_d;
  logic [WIDTH-1:0] diff_reg_q;

  am25ls2521_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i    (cmp.a),
    .b_i    (cmp.b),
    .ein_i  (cmp.ein_),
    .eout_o (eout_c),
    .diff_o (diff_c)
  );

  // Gating diff by the enable keeps the invariant eout_q==0 -> diff_q==0
  // and diff_q!=0 -> eout_q==1.
  always_comb begin
    eout_reg_d = eout_c;
    diff_reg_d = cmp.ein_ ? '0 : diff_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eout_reg_q <= EQ_INACTIVE;
      diff_reg_q <= '0;
    end else begin
      eout_reg_q <= eout_reg_d;
      diff_reg_q <= diff_reg_d;
    end
  end

  assign cmp.eout_  = eout_c;
  assign cmp.eout_q = eout_reg_q;
  assign cmp.diff_q = diff_reg_q;

endmodule

// File: tb/tb_am25ls2521_eqcmp.sv
// tb_am25ls2521_eqcmp
// Table-driven check of the 8-bit comparator plus hand-written reset and
// two-stage cascade sequences.
module tb_am25ls2521_eqcmp;

  localparam int W = 8;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  am25ls2521_eqcmp_if #(.WIDTH(W)) m_if ();
  am25ls2521_eqcmp_if #(.WIDTH(W)) lo_if ();
  am25ls2521_eqcmp_if #(.WIDTH(W)) hi_if ();

  am25ls2521_eqcmp #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .cmp(m_if.slave));
  am25ls2521_eqcmp #(.WIDTH(W)) u_lo  (.clk(clk), .rst(rst), .cmp(lo_if.slave));
  am25ls2521_eqcmp #(.WIDTH(W)) u_hi  (.clk(clk), .rst(rst), .cmp(hi_if.slave));

  // combinational cascade: low stage equal feeds high stage enable
  assign hi_if.ein_ = lo_if.eout_;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ein_;
    logic         exp_eout;
    logic         chk_reg;
    logic [W-1:0] exp_diff;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ein_, input logic exp_eout, input logic chk_reg,
                     input logic [W-1:0] exp_diff);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.ein_ = ein_;
    v.exp_eout = exp_eout; v.chk_reg = chk_reg; v.exp_diff = exp_diff;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] av, bv;

    add("dis_xx",   8'bxxxxxxxx, 8'bxxxxxxxx, 1'b1, 1'b1, 1'b1, 8'h00);
    add("eq_00",    8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    add("eq_ff",    8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00);
    add("eq_cc",    8'hCC, 8'hCC, 1'b0, 1'b0, 1'b1, 8'h00);
    add("eq_55",    8'h55, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
    add("dis_diff", 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < W; i++) begin
      av = 8'bxxxxxxxx; bv = 8'bxxxxxxxx;
      av[i] = (i < 4) ? 1'b0 : 1'b1;
      bv[i] = (i < 4) ? 1'b1 : 1'b0;
      add($sformatf("walk_x%0d", i), av, bv, 1'b0, 1'b1, 1'b0, 8'h00);
    end
    for (int i = 0; i < W; i++) begin
      av = 8'h00; bv = 8'h00;
      bv[i] = 1'b1;
      add($sformatf("walk_k%0d", i), av, bv, 1'b0, 1'b1, 1'b1, 8'h01 << i);
    end

    // reset state
    rst = 1'b1;
    m_if.a = '0; m_if.b = '0; m_if.ein_ = 1'b0;
    lo_if.a = '0; lo_if.b = '0; lo_if.ein_ = 1'b0;
    hi_if.a = '0; hi_if.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_eout_q", {15'd0, m_if.eout_q}, 16'd1);
    chk("rst_diff_q", {8'd0, m_if.diff_q}, 16'd0);
    chk("rst_eout_comb", {15'd0, m_if.eout_}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      m_if.a = vecs[k].a; m_if.b = vecs[k].b; m_if.ein_ = vecs[k].ein_;
      #1;
      chk({vecs[k].name, "_eout"}, {15'd0, m_if.eout_}, {15'd0, vecs[k].exp_eout});
      @(posedge clk);
      #1;
      if (vecs[k].chk_reg) begin
        chk({vecs[k].name, "_eout_q"}, {15'd0, m_if.eout_q}, {15'd0, vecs[k].exp_eout});
        chk({vecs[k].name, "_diff_q"}, {8'd0, m_if.diff_q}, {8'd0, vecs[k].exp_diff});
      end
    end

    // mismatch loaded, then reset with equal inputs overrides it
    @(negedge clk);
    m_if.a = 8'h0F; m_if.b = 8'h00; m_if.ein_ = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_diff_q", {8'd0, m_if.diff_q}, 16'h000F);
    @(negedge clk);
    m_if.a = 8'h5A; m_if.b = 8'h5A;
    @(posedge clk); #1;
    chk("pre_rst_eq_eout_q", {15'd0, m_if.eout_q}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_live_eout", {15'd0, m_if.eout_}, 16'd0);
    @(posedge clk); #1;
    chk("mid_rst_eout_q", {15'd0, m_if.eout_q}, 16'd1);
    chk("mid_rst_diff_q", {8'd0, m_if.diff_q}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_eout_q", {15'd0, m_if.eout_q}, 16'd0);
    chk("post_rst_diff_q", {8'd0, m_if.diff_q}, 16'd0);

    // reset must also clear diff when inputs differ
    @(negedge clk);
    m_if.a = 8'hA0; m_if.b = 8'h05; rst = 1'b1;
    #1;
    chk("rst_diff_live_eout", {15'd0, m_if.eout_}, 16'd1);
    @(posedge clk); #1;
    chk("rst_mis_diff_q", {8'd0, m_if.diff_q}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_mis_diff_q", {8'd0, m_if.diff_q}, 16'h00A5);
    chk("post_rst_mis_eout_q", {15'd0, m_if.eout_q}, 16'd1);

    // 16-bit cascade
    @(negedge clk);
    lo_if.a = 8'h3C; lo_if.b = 8'h3C; lo_if.ein_ = 1'b0;
    hi_if.a = 8'h81; hi_if.b = 8'h81;
    #1;
    chk("cas_all_eq", {15'd0, hi_if.eout_}, 16'd0);
    hi_if.b = 8'h80;
    #1;
    chk("cas_hi_mis", {15'd0, hi_if.eout_}, 16'd1);
    chk("cas_hi_mis_lo", {15'd0, lo_if.eout_}, 16'd0);
    hi_if.b = 8'h81; lo_if.b = 8'hBC;
    #1;
    chk("cas_lo_mis", {15'd0, hi_if.eout_}, 16'd1);
    lo_if.b = 8'h3C; lo_if.ein_ = 1'b1;
    #1;
    chk("cas_dis", {15'd0, hi_if.eout_}, 16'd1);
    @(posedge clk); #1;
    chk("cas_dis_hi_diff_q", {8'd0, hi_if.diff_q}, 16'd0);
    @(negedge clk);
    lo_if.ein_ = 1'b0; hi_if.b = 8'h01;
    @(posedge clk); #1;
    chk("cas_hi_diff_q", {8'd0, hi_if.diff_q}, 16'h0080);
    chk("cas_hi_eout_q", {15'd0, hi_if.eout_q}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am25ls2521_eqcmp.md
Name: am25ls2521_eqcmp

Overview:
- Parameterised N-bit identity (equality) comparator modelled on the Am25LS2521 8-bit comparator. It has active-low cascade enable in and active-low "equal" out.
- The combinational compare path is preserved for cascading.
- It adds a clocked, synchronously reset registered copy of the result and a per-bit mismatch vector for status/debug use in datapath glue logic.

Parameters:
- WIDTH, 8, number of compared bits (must be ≥1).

Ports:
- clk  in  1  single system clock; all registered outputs update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ein_  in  1  active-low cascade enable. 0 = compare enabled; 1 = force "not equal".
- eout_  out  1  combinational active-low equal. 0 only when ein_=0 and a==b bitwise.
- eout_q  out  1  eout_ registered one cycle.
- diff_q  out  WIDTH  registered per-bit mismatch (a XOR b), gated by enable.

Interface note: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Combinational path (zero latency, no clock involvement):
  - eout_ = ein_ OR (OR-reduction of (a XOR b)).
  - ein_=1 → eout_=1 regardless of a/b, including X/Z operands.
  - ein_=0, all bits equal → eout_=0.
  - ein_=0, any single bit differs in known values → eout_=1, even if other bits are X/Z. Implement as a reduction OR so a known 1 dominates unknowns. Do not use the == operator or a case/if on the whole vector.
  - Bit order irrelevant; every bit position 0..WIDTH-1 has equal weight.
- Registered path:
  - On rising clk with rst=1: eout_q←1 (not equal/inactive), diff_q←all 0.
  - Otherwise: eout_q←eout_ and diff_q←(ein_ ? 0 : a XOR b).
  - Latency: exactly 1 cycle from inputs to eout_q/diff_q.
  - Reset does not affect the combinational eout_. It stays live during reset.
  - Reset asserted mid-stream: the next edge loads reset values, overriding the current inputs. The first edge after rst deasserts captures the then-current inputs.
  - Invariant after any non-reset edge: eout_q==0 implies diff_q==0. diff_q!=0 implies eout_q==1.
- Cascading: eout_ of stage k connects to ein_ of stage k+1 for widths beyond WIDTH. This is combinational only and must not pass through eout_q.
- No state other than the two registers; no handshakes.

Decomposition:
- No shared package needed; optionally define the constant EQ_ACTIVE=1'b0 in the common constants package.
- Natural sub-module: am25ls2521_core. It is purely combinational: a, b, ein_ → eout_ and a diff vector. The top adds the registers.

Test Plan:
- ein_=1, a=b=8'bxxxxxxxx → eout_=1. After clk, eout_q=1 and diff_q=0.
- ein_=0 with equal operands (a=b=00000000, then 11111111, 11001100, 01010101) → eout_=0 each. After clk, eout_q=0 and diff_q=0.
- ein_=0, walking single mismatch at bit i=0..7, all other bits X. Bits 0–3: a=0, b=1. Bits 4–7: a=1, b=0. Expect eout_=1 for every i.
- Same walk with the other bits known and equal (e.g. 0). After clk, diff_q=(1<<i) and eout_q=1.
- rst=1 for one edge while a=b, ein_=0 → eout_=0 combinationally. After the edge, eout_q=1 and diff_q=0. Next edge with rst=0 → eout_q=0.
- Cascade two instances (16 bits): mismatch only in the high byte → final eout_=1. All equal → 0. First stage ein_=1 → final eout_=1.
